// File: rtl/ud_count_tracker.sv
// Monitor/decoder for an up/down counter: recovers direction and step events from the sampled
// count, locks on consistent stepping, and flags illegal jumps and stalls.
module ud_count_tracker #(
    parameter int WIDTH       = 3,
    parameter int LOCK_COUNT  = 4,
    parameter int STALL_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    output logic             dir,
    output logic             step,
    output logic             dir_change,
    output logic             locked,
    output logic             stall,
    output logic             err,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DELTA_UP   = WIDTH'(1);
    localparam logic [WIDTH-1:0] DELTA_DOWN = '1;
    localparam logic [WIDTH-1:0] DELTA_HOLD = '0;
    localparam logic [3:0]       LOCK_RUN   = 4'(LOCK_COUNT);
    localparam logic [7:0]       STALL_MAX  = 8'(STALL_LIMIT);

    state_t           state, nxt_state;
    logic [WIDTH-1:0] prev, nxt_prev;
    logic [3:0]       run, nxt_run;
    logic [7:0]       scnt, nxt_scnt;
    logic [7:0]       nxt_err_cnt;
    logic             nxt_dir, nxt_step, nxt_dir_change, nxt_stall, nxt_err;

    logic [WIDTH-1:0] delta;
    logic             is_up, is_down, is_hold, is_step;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] stall_inc(input logic [7:0] v);
        return (v >= STALL_MAX) ? STALL_MAX : v + 8'd1;
    endfunction

    // Modular difference makes wrap-around (max->0, 0->max) a legal single step.
    assign delta   = q_in - prev;
    assign is_up   = (delta == DELTA_UP);
    assign is_down = (delta == DELTA_DOWN);
    assign is_hold = (delta == DELTA_HOLD);
    assign is_step = is_up | is_down;

    always_comb begin
        nxt_state      = state;
        nxt_prev       = prev;
        nxt_run        = run;
        nxt_scnt       = scnt;
        nxt_dir        = dir;
        nxt_stall      = stall;
        nxt_err_cnt    = err_cnt;
        nxt_step       = 1'b0;
        nxt_dir_change = 1'b0;
        nxt_err        = 1'b0;

        if (en) begin
            nxt_prev = q_in;
            case (state)
                IDLE: begin
                    nxt_state = ACQUIRE;
                    nxt_run   = 4'd0;
                end
                ACQUIRE: begin
                    if (is_step) begin
                        nxt_step = 1'b1;
                        nxt_dir  = is_up;
                        // An opposite step restarts the run at one instead of zero.
                        if (is_up == dir || run == 4'd0)
                            nxt_run = run + 4'd1;
                        else
                            nxt_run = 4'd1;
                        if (nxt_run == LOCK_RUN)
                            nxt_state = LOCKED;
                    end else if (!is_hold) begin
                        nxt_err     = 1'b1;
                        nxt_err_cnt = sat_inc8(err_cnt);
                        nxt_run     = 4'd0;
                    end
                end
                LOCKED: begin
                    if (is_step) begin
                        nxt_step  = 1'b1;
                        nxt_scnt  = 8'd0;
                        nxt_stall = 1'b0;
                        if (is_up != dir) begin
                            nxt_dir        = is_up;
                            nxt_dir_change = 1'b1;
                        end
                    end else if (is_hold) begin
                        nxt_scnt  = stall_inc(scnt);
                        nxt_stall = (nxt_scnt == STALL_MAX);
                    end else begin
                        nxt_err     = 1'b1;
                        nxt_err_cnt = sat_inc8(err_cnt);
                        nxt_run     = 4'd0;
                        nxt_scnt    = 8'd0;
                        nxt_stall   = 1'b0;
                        nxt_state   = ACQUIRE;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            prev       <= '0;
            run        <= 4'd0;
            scnt       <= 8'd0;
            dir        <= 1'b1;
            step       <= 1'b0;
            dir_change <= 1'b0;
            stall      <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= 8'd0;
            locked     <= 1'b0;
        end else begin
            state      <= nxt_state;
            prev       <= nxt_prev;
            run        <= nxt_run;
            scnt       <= nxt_scnt;
            dir        <= nxt_dir;
            step       <= nxt_step;
            dir_change <= nxt_dir_change;
            stall      <= nxt_stall;
            err        <= nxt_err;
            err_cnt    <= nxt_err_cnt;
            locked     <= (nxt_state == LOCKED);
        end
    end

endmodule

// File: tb/tb_ud_count_tracker.sv
// Directed bench for ud_count_tracker (WIDTH=3, LOCK_COUNT=4, STALL_LIMIT=8).
module tb_ud_count_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [2:0] q_in = 3'd0;
    logic       dir, step, dir_change, locked, stall, err;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ud_count_tracker #(.WIDTH(3), .LOCK_COUNT(4), .STALL_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in),
        .dir(dir), .step(step), .dir_change(dir_change), .locked(locked),
        .stall(stall), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic samp(input logic [2:0] q);
        rst  = 1'b1;
        en   = 1'b1;
        q_in = q;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input logic [2:0] q);
        rst  = 1'b1;
        en   = 1'b0;
        q_in = q;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        en  = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        q_in = 3'd5;
        do_reset(2);
        chk("rst_dir", dir, 1);
        chk("rst_step", step, 0);
        chk("rst_dchg", dir_change, 0);
        chk("rst_locked", locked, 0);
        chk("rst_stall", stall, 0);
        chk("rst_err", err, 0);
        chk("rst_errcnt", err_cnt, 0);

        // Up with wrap 7->0
        samp(3'd5);
        chk("up_cap_step", step, 0);
        chk("up_cap_err", err, 0);
        samp(3'd6);
        chk("up6_step", step, 1);
        chk("up6_locked", locked, 0);
        samp(3'd7);
        chk("up7_step", step, 1);
        samp(3'd0);
        chk("up0_step", step, 1);
        chk("up0_locked", locked, 0);
        chk("up0_err", err, 0);
        samp(3'd1);
        chk("up1_step", step, 1);
        chk("up1_dir", dir, 1);
        chk("up1_locked", locked, 1);

        // Down with wrap 0->7
        do_reset(1);
        samp(3'd2);
        chk("dn_cap_step", step, 0);
        samp(3'd1);
        chk("dn1_step", step, 1);
        chk("dn1_dir", dir, 0);
        samp(3'd0);
        samp(3'd7);
        chk("dn7_step", step, 1);
        chk("dn7_locked", locked, 0);
        samp(3'd6);
        chk("dn6_step", step, 1);
        chk("dn6_dir", dir, 0);
        chk("dn6_locked", locked, 1);
        chk("dn6_err", err, 0);
        chk("dn6_errcnt", err_cnt, 0);

        // Reverse while locked
        do_reset(1);
        samp(3'd7);
        samp(3'd0);
        samp(3'd1);
        samp(3'd2);
        samp(3'd3);
        chk("rev_locked_up", locked, 1);
        chk("rev_pre_dchg", dir_change, 0);
        samp(3'd2);
        chk("rev_step", step, 1);
        chk("rev_dir", dir, 0);
        chk("rev_dchg", dir_change, 1);
        chk("rev_locked", locked, 1);
        samp(3'd2);
        chk("rev_dchg_pulse", dir_change, 0);
        chk("rev_hold_step", step, 0);

        // Illegal jump, relock, counter saturation
        do_reset(1);
        samp(3'd6);
        samp(3'd7);
        samp(3'd0);
        samp(3'd1);
        samp(3'd2);
        chk("ill_pre_locked", locked, 1);
        samp(3'd5);
        chk("ill_err", err, 1);
        chk("ill_errcnt", err_cnt, 1);
        chk("ill_step", step, 0);
        chk("ill_locked", locked, 0);
        samp(3'd6);
        chk("relk6_err", err, 0);
        chk("relk6_step", step, 1);
        chk("relk6_locked", locked, 0);
        samp(3'd7);
        samp(3'd0);
        chk("relk0_locked", locked, 0);
        samp(3'd1);
        chk("relk1_locked", locked, 1);
        for (int i = 0; i < 300; i++) begin
            samp((i % 2 == 0) ? 3'd5 : 3'd1);
            if (i == 252) chk("sat_254", err_cnt, 254);
        end
        chk("sat_errcnt", err_cnt, 255);
        chk("sat_err", err, 1);
        chk("sat_step", step, 0);

        // Stall with en gaps, then reset mid-lock
        do_reset(1);
        samp(3'd0);
        samp(3'd1);
        samp(3'd2);
        samp(3'd3);
        samp(3'd4);
        chk("stl_locked", locked, 1);
        repeat (3) samp(3'd4);
        gap(3'd7);
        gap(3'd7);
        gap(3'd7);
        chk("stl_gap_stall", stall, 0);
        chk("stl_gap_step", step, 0);
        repeat (4) samp(3'd4);
        chk("stl_7th", stall, 0);
        samp(3'd4);
        chk("stl_8th", stall, 1);
        chk("stl_locked2", locked, 1);
        gap(3'd2);
        chk("stl_gap_hold", stall, 1);
        samp(3'd4);
        chk("stl_9th", stall, 1);
        samp(3'd5);
        chk("stl_clr_step", step, 1);
        chk("stl_clr", stall, 0);
        do_reset(1);
        chk("mid_rst_locked", locked, 0);
        samp(3'd4);
        chk("mid_cap_err", err, 0);
        chk("mid_cap_step", step, 0);
        chk("mid_cap_errcnt", err_cnt, 0);
        samp(3'd6);
        chk("mid_ill_err", err, 1);
        chk("mid_ill_errcnt", err_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
